// File: rtl/stroke_pkg.sv
// Shared constants, state encoding and helpers for the stroke sequencer.
package stroke_pkg;

  localparam int CW          = 8;
  localparam int DIGIT_COUNT = 10;
  localparam int HOME_X      = 0;
  localparam int HOME_Y      = 0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    SETTLE = 3'd2,
    ISSUE  = 3'd3,
    DONE   = 3'd4
  } seq_state_e;

  function automatic logic [DIGIT_COUNT-1:0] digit_onehot(input logic [3:0] digit);
    digit_onehot = {{(DIGIT_COUNT-1){1'b0}}, 1'b1} << digit;
  endfunction

endpackage

// File: rtl/pen_settle_timer.sv
// Pen servo settle down-counter: load a start value, count to zero, flag expiry.
module pen_settle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         count,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_r;

  // Load has priority; counting stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (count && (cnt_r != '0)) begin
      cnt_r <= cnt_r - W'(1);
    end
  end

  assign expired = (cnt_r == '0);

endmodule

// File: rtl/stroke_sequencer.sv
// Walks a digit's stroke table, settles the pen on changes and hands segments downstream.
// Optional STROKE_CONTINUITY_CHECK_EN adds a sticky cont_err output for broken stroke chains.
module stroke_sequencer
  import stroke_pkg::*;
#(
  parameter int MAX_SEG    = 32,
  parameter int PEN_SETTLE = 25000,
  parameter int CW         = stroke_pkg::CW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [3:0]             digit_sel,
  output logic [4:0]             tbl_idx,
  output logic [DIGIT_COUNT-1:0] tbl_en,
  input  logic [CW-1:0]          tbl_sx,
  input  logic [CW-1:0]          tbl_sy,
  input  logic [CW-1:0]          tbl_ex,
  input  logic [CW-1:0]          tbl_ey,
  input  logic                   tbl_pen,
  output logic                   seg_valid,
  input  logic                   seg_ready,
  output logic [CW-1:0]          seg_sx,
  output logic [CW-1:0]          seg_sy,
  output logic [CW-1:0]          seg_ex,
  output logic [CW-1:0]          seg_ey,
  output logic                   seg_pen,
  output logic                   pen_cmd,
  output logic                   busy,
  output logic                   done
`ifdef STROKE_CONTINUITY_CHECK_EN
  ,
  output logic                   cont_err
`endif
);

  localparam int CNT_W = (PEN_SETTLE > 32'sd1) ? $clog2(PEN_SETTLE) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = (PEN_SETTLE > 32'sd0) ? CNT_W'(PEN_SETTLE - 32'sd1) : '0;
  localparam logic SETTLE_EN = (PEN_SETTLE > 32'sd0);
  localparam logic [4:0] IDX_LAST = 5'(MAX_SEG - 32'sd1);

  seq_state_e state_r, state_nxt_s;

  logic [4:0]             idx_r;
  logic [DIGIT_COUNT-1:0] tbl_en_r;
  logic [CW-1:0]          seg_sx_r, seg_sy_r, seg_ex_r, seg_ey_r;
  logic                   seg_pen_r, pen_cmd_r;
  logic                   seg_valid_r, busy_r, done_r;
  logic                   start_ok_s, pen_change_s, xfer_s, last_s, settle_done_s;

  assign start_ok_s   = start && (digit_sel < 4'(DIGIT_COUNT));
  assign pen_change_s = (tbl_pen != pen_cmd_r);
  assign xfer_s       = (state_r == ISSUE) && seg_ready;
  // Return-to-origin with pen up ends the digit; idx 0 may legitimately start at home.
  assign last_s = ((seg_ex_r == CW'(HOME_X)) && (seg_ey_r == CW'(HOME_Y)) && !seg_pen_r && (idx_r != 5'd0))
                  || (idx_r == IDX_LAST);

  pen_settle_timer #(.W(CNT_W)) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     ((state_r == FETCH) && pen_change_s),
    .count    (state_r == SETTLE),
    .load_val (SETTLE_LOAD),
    .expired  (settle_done_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (start_ok_s) state_nxt_s = FETCH; else state_nxt_s = IDLE;
      FETCH:   if (pen_change_s && SETTLE_EN) state_nxt_s = SETTLE; else state_nxt_s = ISSUE;
      SETTLE:  if (settle_done_s) state_nxt_s = ISSUE; else state_nxt_s = SETTLE;
      ISSUE: begin
        if (xfer_s) begin
          if (last_s) state_nxt_s = DONE;
          else        state_nxt_s = FETCH;
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

`ifdef STROKE_CONTINUITY_CHECK_EN
  logic cont_err_r;
`endif

  // Segment datapath, table index and pen command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r     <= 5'd0;
      tbl_en_r  <= '0;
      seg_sx_r  <= '0;
      seg_sy_r  <= '0;
      seg_ex_r  <= '0;
      seg_ey_r  <= '0;
      seg_pen_r <= 1'b0;
      pen_cmd_r <= 1'b0;
`ifdef STROKE_CONTINUITY_CHECK_EN
      cont_err_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (start_ok_s) begin
            idx_r    <= 5'd0;
            tbl_en_r <= digit_onehot(digit_sel);
`ifdef STROKE_CONTINUITY_CHECK_EN
            cont_err_r <= 1'b0;
`endif
          end
        end
        FETCH: begin
          seg_sx_r  <= tbl_sx;
          seg_sy_r  <= tbl_sy;
          seg_ex_r  <= tbl_ex;
          seg_ey_r  <= tbl_ey;
          seg_pen_r <= tbl_pen;
          if (pen_change_s) pen_cmd_r <= tbl_pen;
`ifdef STROKE_CONTINUITY_CHECK_EN
          // seg_ex_r/seg_ey_r still hold the previous segment's endpoint here.
          if ((idx_r != 5'd0) && ((tbl_sx != seg_ex_r) || (tbl_sy != seg_ey_r))) cont_err_r <= 1'b1;
`endif
        end
        ISSUE: begin
          if (xfer_s) begin
            if (last_s) begin
              tbl_en_r  <= '0;
              pen_cmd_r <= 1'b0;
            end else begin
              idx_r <= idx_r + 5'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Status outputs registered from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      seg_valid_r <= (state_nxt_s == ISSUE);
      busy_r      <= (state_nxt_s != IDLE);
      done_r      <= (state_nxt_s == DONE);
    end
  end

  assign tbl_idx   = idx_r;
  assign tbl_en    = tbl_en_r;
  assign seg_sx    = seg_sx_r;
  assign seg_sy    = seg_sy_r;
  assign seg_ex    = seg_ex_r;
  assign seg_ey    = seg_ey_r;
  assign seg_pen   = seg_pen_r;
  assign pen_cmd   = pen_cmd_r;
  assign seg_valid = seg_valid_r;
  assign busy      = busy_r;
  assign done      = done_r;
`ifdef STROKE_CONTINUITY_CHECK_EN
  assign cont_err  = cont_err_r;
`endif

endmodule
